button_pulse_gen: RTL and testbench

//   Turns a raw, bouncing pushbutton into clean single-cycle enable pulses.

---
 rtl/button_pulse_gen.sv | 165 ++++++++++++++++
 tb/tb_button_pulse_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// button_pulse_gen
//   Turns a raw, bouncing pushbutton into clean single-cycle enable pulses for a
//   downstream event counter, with optional auto-repeat while the button is held.
//
// Ports
//   clock      in   system clock, all logic on posedge
//   reset      in   asynchronous active-high reset, clears all state
//   btn_raw    in   raw asynchronous button level, 1 = pressed
//   repeat_en  in   1 = emit repeat pulses while held (sampled every cycle)
//   pulse      out  one-cycle enable pulse per accepted press or repeat
//   held       out  1 while the debounced button state is pressed
module button_pulse_gen #(
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 10,
    parameter int unsigned REPEAT_RATE     = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StReleaseDb
    } state_e;

    localparam logic [CNT_W-1:0] DbTarget  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RepDelay  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RepRate   = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam bit               SingleDb  = (DEBOUNCE_CYCLES == 1);

    logic             sync1_q, btn_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] db_q, db_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    // Set once the first repeat has fired; selects RATE instead of DELAY.
    logic             rep_first_q, rep_first_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;

    logic [CNT_W-1:0] db_inc, rep_inc, rep_target;

    // Saturating increments so the timers never wrap.
    assign db_inc     = (db_q == CntMax) ? db_q : db_q + CntOne;
    assign rep_inc    = (rep_q == CntMax) ? rep_q : rep_q + CntOne;
    assign rep_target = rep_first_q ? RepRate : RepDelay;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            state_q     <= StIdle;
            db_q        <= '0;
            rep_q       <= '0;
            rep_first_q <= 1'b0;
            pulse_q     <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            btn_s_q     <= sync1_q;
            state_q     <= state_d;
            db_q        <= db_d;
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
            pulse_q     <= pulse_d;
            held_q      <= held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_d        = db_q;
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        pulse_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (btn_s_q) begin
                    // The sampling edge itself counts as the first stable cycle.
                    if (SingleDb) begin
                        state_d     = StHeld;
                        pulse_d     = 1'b1;
                        db_d        = '0;
                        rep_d       = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        state_d = StPressDb;
                        db_d    = CntOne;
                    end
                end
            end
            StPressDb: begin
                if (!btn_s_q) begin
                    state_d = StIdle;
                    db_d    = '0;
                end else if (db_inc >= DbTarget) begin
                    state_d     = StHeld;
                    pulse_d     = 1'b1;
                    db_d        = '0;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else begin
                    db_d = db_inc;
                end
            end
            StHeld: begin
                if (!btn_s_q) begin
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                    if (SingleDb) begin
                        state_d = StIdle;
                        db_d    = '0;
                    end else begin
                        state_d = StReleaseDb;
                        db_d    = CntOne;
                    end
                end else if (!repeat_en) begin
                    // Disabling repeat restarts the initial delay on re-enable.
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else if (rep_inc >= rep_target) begin
                    pulse_d     = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b1;
                end else begin
                    rep_d = rep_inc;
                end
            end
            StReleaseDb: begin
                if (btn_s_q) begin
                    // Release bounce: back to held without a new press pulse.
                    state_d     = StHeld;
                    db_d        = '0;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else if (db_inc >= DbTarget) begin
                    state_d = StIdle;
                    db_d    = '0;
                end else begin
                    db_d = db_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        held_d = (state_d == StHeld) || (state_d == StReleaseDb);
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen
//   Directed bench for button_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_RATE=3. Cycle c is the interval after posedge c; btn_raw is driven 1ns
//   after posedge c and outputs are sampled on the following negedge.
//   A level first driven in cycle P reaches the FSM at edge P+3, so a clean press
//   pulses in cycle P+6 and a release first driven in cycle L clears held in L+6.
module tb_button_pulse_gen;

    logic clock;
    logic reset;
    logic btn_raw;
    logic repeat_en;
    logic pulse;
    logic held;

    int n_checks;
    int n_errors;

    logic [127:0] pulse_v;
    logic [127:0] held_v;

    button_pulse_gen #(
        .CNT_W          (20),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .repeat_en(repeat_en),
        .pulse    (pulse),
        .held     (held)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] bit_at(input int i);
        logic [127:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // Drive pat[c] in cycle c for n cycles and log the outputs of every cycle.
    task automatic run(input logic [127:0] pat, input int n, input logic ren);
        repeat_en = ren;
        pulse_v   = '0;
        held_v    = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            #1;
            btn_raw = pat[c];
            @(negedge clock);
            pulse_v[c] = pulse;
            held_v[c]  = held;
        end
    endtask

    initial begin
        logic [127:0] pat;
        logic [127:0] exp_p;

        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        btn_raw   = 1'b0;
        repeat_en = 1'b0;
        pulse_v   = '0;
        held_v    = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_pulse", {127'b0, pulse}, 128'd0);
        check("reset_held", {127'b0, held}, 128'd0);
        reset = 1'b0;

        // 1: clean press cycles 0..7, no repeat.
        run(span(0, 7), 20, 1'b0);
        check("t1_pulse", pulse_v, bit_at(6));
        check("t1_held", held_v, span(6, 13));

        // 2: bounce 1,0,1,0 then stable high 4..15; last rise at cycle 4.
        pat = span(4, 15);
        pat[0] = 1'b1;
        pat[2] = 1'b1;
        run(pat, 26, 1'b0);
        check("t2_pulse", pulse_v, bit_at(10));
        check("t2_held", held_v, span(10, 21));

        // 3: glitch shorter than the debounce window.
        run(span(0, 2), 12, 1'b0);
        check("t3_pulse", pulse_v, 128'd0);
        check("t3_held", held_v, 128'd0);

        // 4: long hold with auto-repeat.
        run(span(0, 31), 45, 1'b1);
        exp_p = bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25) | bit_at(28)
              | bit_at(31) | bit_at(34);
        check("t4_pulse", pulse_v, exp_p);
        check("t4_count", 128'($countones(pulse_v)), 128'd8);
        check("t4_held", held_v, span(6, 37));

        // 4b: long hold with repeat disabled gives a single pulse.
        run(span(0, 19), 30, 1'b0);
        check("t4b_pulse", pulse_v, bit_at(6));
        check("t4b_held", held_v, span(6, 25));

        // 5: release bounce 0,1,0 while held.
        pat = span(0, 9);
        pat[11] = 1'b1;
        run(pat, 22, 1'b0);
        check("t5_pulse", pulse_v, bit_at(6));
        check("t5_held", held_v, span(6, 17));

        // 6: reset during cycles 5..7 of a press, button kept down.
        repeat_en = 1'b0;
        pulse_v   = '0;
        held_v    = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            btn_raw = 1'b1;
            reset   = (c >= 5) && (c < 8);
            @(negedge clock);
            pulse_v[c] = pulse;
            held_v[c]  = held;
        end
        check("t6_pulse", pulse_v, bit_at(14));
        check("t6_held", held_v, span(14, 19));

        // Asynchronous clear mid-cycle, with no clock edge in between.
        #2;
        reset = 1'b1;
        #1;
        check("async_held", {127'b0, held}, 128'd0);
        check("async_pulse", {127'b0, pulse}, 128'd0);
        btn_raw = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        run(128'd0, 12, 1'b0);
        check("post_reset_idle", held_v | pulse_v, 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
